// File: rtl/starship_cov_pkg.sv
// rtl/starship_cov_pkg.sv - shared widths and types for the coverage accumulator
package starship_cov_pkg;

    localparam int DEFAULT_COV_W = 30;

    typedef logic [DEFAULT_COV_W-1:0] cov_sum_t;

    function automatic int lane_cnt_width(input int lane);
        return $clog2(lane + 1);
    endfunction

    function automatic int delta_width(input int n_points);
        return $clog2(n_points + 1);
    endfunction

endpackage

// File: rtl/cov_popcount_lane.sv
// rtl/cov_popcount_lane.sv - combinational popcount of one coverage lane
module cov_popcount_lane
    import starship_cov_pkg::*;
#(
    parameter int LANE  = 16,
    parameter int CNT_W = lane_cnt_width(LANE)
) (
    input  logic [LANE-1:0]  lane_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < LANE; i++) begin
            count_o = count_o + CNT_W'(lane_i[i]);
        end
    end

endmodule

// File: rtl/coverage_accumulator.sv
// rtl/coverage_accumulator.sv - sticky coverage bitmap with a pipelined saturating distinct-hit count
module coverage_accumulator
    import starship_cov_pkg::*;
#(
    parameter int N_POINTS = 256,
    parameter int LANE     = 16,
    parameter int COV_W    = DEFAULT_COV_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cov_clear,
    input  logic                cov_valid,
    input  logic [N_POINTS-1:0] cov_hit,
    output logic [COV_W-1:0]    cov_sum,
    output logic                cov_new,
    output logic                cov_full
);

    localparam int N_LANES = N_POINTS / LANE;
    localparam int CNT_W   = lane_cnt_width(LANE);
    localparam int DELTA_W = delta_width(N_POINTS);
    // The adder must hold a full delta even when COV_W is narrower than it.
    localparam int SUM_W   = ((COV_W > DELTA_W) ? COV_W : DELTA_W) + 1;
    localparam logic [COV_W-1:0] SUM_MAX = '1;

    logic [N_POINTS-1:0]             seen_q;
    logic [N_POINTS-1:0]             seen_d;
    logic [N_POINTS-1:0]             new_vec_q;
    logic [N_POINTS-1:0]             new_vec_d;
    logic [N_LANES-1:0][CNT_W-1:0]   lane_cnt_q;
    logic [N_LANES-1:0][CNT_W-1:0]   lane_cnt_d;
    logic [COV_W-1:0]                sum_q;
    logic [COV_W-1:0]                sum_d;
    logic                            new_q;
    logic                            new_d;
    logic                            full_q;
    logic [DELTA_W-1:0]              delta;
    logic [SUM_W-1:0]                sum_wide;

    always_comb begin
        new_vec_d = cov_valid ? (cov_hit & ~seen_q) : '0;
        seen_d    = seen_q | new_vec_d;
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        cov_popcount_lane #(
            .LANE  (LANE),
            .CNT_W (CNT_W)
        ) u_lane (
            .lane_i  (new_vec_q[k*LANE +: LANE]),
            .count_o (lane_cnt_d[k])
        );
    end

    always_comb begin
        delta = '0;
        for (int k = 0; k < N_LANES; k++) begin
            delta = delta + DELTA_W'(lane_cnt_q[k]);
        end
        sum_wide = SUM_W'(sum_q) + SUM_W'(delta);
        if (sum_wide > SUM_W'(SUM_MAX)) begin
            sum_d = SUM_MAX;
        end else begin
            sum_d = sum_wide[COV_W-1:0];
        end
        new_d = (delta != '0);
    end

    // cov_full tracks the previous bitmap, so it lags a clear by one edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_q     <= '0;
            new_vec_q  <= '0;
            lane_cnt_q <= '0;
            sum_q      <= '0;
            new_q      <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            full_q <= &seen_q;
            if (cov_clear) begin
                seen_q     <= '0;
                new_vec_q  <= '0;
                lane_cnt_q <= '0;
                sum_q      <= '0;
                new_q      <= 1'b0;
            end else begin
                seen_q     <= seen_d;
                new_vec_q  <= new_vec_d;
                lane_cnt_q <= lane_cnt_d;
                sum_q      <= sum_d;
                new_q      <= new_d;
            end
        end
    end

    assign cov_sum  = sum_q;
    assign cov_new  = new_q;
    assign cov_full = full_q;

endmodule
